// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED controller: NUM_CH channels in direct, blink or PWM mode,
// driven from a shared prescaled tick, with a level interrupt on PWM wrap.
module led_pwm_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h2000_0000,
  parameter int          NUM_CH        = 4,
  parameter int          PWM_BITS      = 8,
  parameter int          PRESCALE_BITS = 16
) (
  input  logic              sys_clock,
  input  logic              sys_reset_n,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_valid,
  output logic [NUM_CH-1:0] led_out,
  output logic              irq
);

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_PWM    = 2'd2;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

  logic                     hit, wr, tick_p0, wrap_evt, wrap_clr, pre_wr;
  logic [5:0]               word;
  logic [NUM_CH-1:0]        led_reg, ch_wr, led_nxt;
  logic                     ctrl_en, ctrl_irq_en, wrap;
  logic [PRESCALE_BITS-1:0] prescale, pre_cnt;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [1:0]               ch_mode   [NUM_CH];
  logic [7:0]               ch_duty   [NUM_CH];
  logic [15:0]              ch_half   [NUM_CH];
  logic [15:0]              blk_cnt   [NUM_CH];
  logic                     blk_state [NUM_CH];
  logic [31:0]              ch_wval   [NUM_CH];
  logic [31:0]              led_wval, ctrl_wval, pre_wval, rd_val;
  logic                     unused_bits, unused_ch;

  assign hit      = data_req && (data_addr[31:8] == BASE_ADDR[31:8]);
  assign wr       = hit && data_we;
  assign word     = data_addr[7:2];
  assign pre_wr   = wr && (word == 6'd2);
  assign wrap_clr = wr && (word == 6'd3) && data_be[0] && data_wdata[0];
  assign tick_p0  = ctrl_en && (pre_cnt == prescale);
  assign wrap_evt = tick_p0 && (pwm_cnt == '1);
  assign irq      = wrap && ctrl_irq_en;

  assign led_wval  = be_merge(32'(led_reg), data_wdata, data_be);
  assign ctrl_wval = be_merge({30'b0, ctrl_irq_en, ctrl_en}, data_wdata, data_be);
  assign pre_wval  = be_merge(32'(prescale), data_wdata, data_be);

  always_comb begin
    unused_ch = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wr[i]   = wr && (word == 6'(4 + i));
      ch_wval[i] = be_merge({ch_half[i], ch_duty[i], 6'b0, ch_mode[i]}, data_wdata, data_be);
      unused_ch  = unused_ch ^ (^ch_wval[i]);
    end
  end

  assign unused_bits = ^{data_addr[1:0], led_wval, ctrl_wval, pre_wval, unused_ch};

  always_comb begin
    rd_val = '0;
    case (word)
      6'd0: rd_val = 32'(led_reg);
      6'd1: rd_val = {30'b0, ctrl_irq_en, ctrl_en};
      6'd2: rd_val = 32'(prescale);
      6'd3: rd_val = {31'b0, wrap};
      default:
        for (int i = 0; i < NUM_CH; i++)
          if (word == 6'(4 + i)) rd_val = {ch_half[i], ch_duty[i], 6'b0, ch_mode[i]};
    endcase
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (ch_mode[i])
        MODE_DIRECT: led_nxt[i] = led_reg[i];
        MODE_BLINK:  led_nxt[i] = ctrl_en && blk_state[i];
        MODE_PWM:    led_nxt[i] = ctrl_en && (pwm_cnt < ch_duty[i][PWM_BITS-1:0]);
        default:     led_nxt[i] = 1'b0;
      endcase
    end
  end

  // Register file; a wrap event takes priority over a W1C clear of WRAP
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      led_reg     <= '0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      prescale    <= '0;
      wrap        <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_mode[i] <= '0;
        ch_duty[i] <= '0;
        ch_half[i] <= '0;
      end
    end else begin
      if (wr && (word == 6'd0)) led_reg <= led_wval[NUM_CH-1:0];
      if (wr && (word == 6'd1)) begin
        ctrl_en     <= ctrl_wval[0];
        ctrl_irq_en <= ctrl_wval[1];
      end
      if (pre_wr) prescale <= pre_wval[PRESCALE_BITS-1:0];
      if (wrap_evt)      wrap <= 1'b1;
      else if (wrap_clr) wrap <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_wr[i]) begin
          ch_mode[i] <= ch_wval[i][1:0];
          ch_duty[i] <= ch_wval[i][15:8];
          ch_half[i] <= ch_wval[i][31:16];
        end
      end
    end
  end

  // Tick stage: prescaler, PWM counter and blink state
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        blk_cnt[i]   <= '0;
        blk_state[i] <= 1'b0;
      end
    end else begin
      if (!ctrl_en || pre_wr || tick_p0) pre_cnt <= '0;
      else                               pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
      if (!ctrl_en)     pwm_cnt <= '0;
      else if (tick_p0) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ctrl_en || ch_wr[i]) begin
          blk_cnt[i]   <= '0;
          blk_state[i] <= 1'b0;
        end else if (tick_p0 && (ch_mode[i] == MODE_BLINK)) begin
          if (blk_cnt[i] == ch_half[i]) begin
            blk_cnt[i]   <= '0;
            blk_state[i] <= ~blk_state[i];
          end else begin
            blk_cnt[i] <= blk_cnt[i] + 16'd1;
          end
        end
      end
    end
  end

  // Output stage: registered LED drive and bus response
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      led_out    <= '0;
      data_rdata <= '0;
      data_valid <= 1'b0;
    end else begin
      led_out    <= led_nxt;
      data_valid <= hit;
      data_rdata <= (hit && !data_we) ? rd_val : 32'd0;
    end
  end

endmodule
